// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format constants and immediate-extension helper
// used by the fetch queue and its field decoder.
package mips_pkg;

   localparam int OP_HI = 31;
   localparam int OP_LO = 26;
   localparam int RS_HI = 25;
   localparam int RS_LO = 21;
   localparam int RT_HI = 20;
   localparam int RT_LO = 16;
   localparam int RD_HI = 15;
   localparam int RD_LO = 11;
   localparam int SH_HI = 10;
   localparam int SH_LO = 6;
   localparam int FN_HI = 5;
   localparam int FN_LO = 0;

   localparam logic [1:0] EXT_ZERO  = 2'b00;
   localparam logic [1:0] EXT_SIGN  = 2'b01;
   localparam logic [1:0] EXT_UPPER = 2'b10;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // The reserved encoding yields zero rather than aliasing another mode.
   function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic [1:0] mode);
      logic [31:0] res;
      case (mode)
         EXT_ZERO:  res = {16'h0000, imm};
         EXT_SIGN:  res = {{16{imm[15]}}, imm};
         EXT_UPPER: res = {imm, 16'h0000};
         default:   res = 32'h0000_0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational split of a 32-bit MIPS word into its fields plus the
// extended immediate selected by ext_op.
module instr_fields
   import mips_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  ext_op,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  func,
   output logic [15:0] addr16,
   output logic [25:0] addr26,
   output logic [31:0] imm32
);

   assign op     = word[OP_HI:OP_LO];
   assign rs     = word[RS_HI:RS_LO];
   assign rt     = word[RT_HI:RT_LO];
   assign rd     = word[RD_HI:RD_LO];
   assign shamt  = word[SH_HI:SH_LO];
   assign func   = word[FN_HI:FN_LO];
   assign addr16 = word[15:0];
   assign addr26 = word[25:0];
   assign imm32  = ext_imm(word[15:0], ext_op);

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular {pc, instr} buffer between fetch and decode; the head is presented
// pre-decoded, and an empty queue presents an all-zero NOP.
module instr_fetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [31:0]      out_instr,
   output logic [5:0]       op,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       func,
   output logic [15:0]      addr16,
   output logic [25:0]      addr26,
   input  logic [1:0]       ext_op,
   output logic [31:0]      imm32,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PC_W-1:0]  mem_pc    [DEPTH];
   logic [31:0]      mem_instr [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic [31:0]      head_word;

   // A full queue refuses input even when decode pops the same cycle.
   assign in_ready  = reset_n && !flush && (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is never cleared; push already excludes reset and flush cycles.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]    <= in_pc;
         mem_instr[wr_ptr] <= in_instr;
      end
   end

   assign head_word = out_valid ? mem_instr[rd_ptr] : NOP_WORD;
   assign out_instr = head_word;
   assign out_pc    = out_valid ? mem_pc[rd_ptr] : '0;

   instr_fields u_fields (
      .word   (head_word),
      .ext_op (ext_op),
      .op     (op),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .shamt  (shamt),
      .func   (func),
      .addr16 (addr16),
      .addr26 (addr26),
      .imm32  (imm32)
   );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4, PC_W=32).
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  func;
   logic [15:0] addr16;
   logic [25:0] addr26;
   logic [1:0]  ext_op;
   logic [31:0] imm32;
   logic [2:0]  count;

   int total  = 0;
   int passed = 0;

   instr_fetch_queue #(.DEPTH(4), .PC_W(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .op        (op),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .shamt     (shamt),
      .func      (func),
      .addr16    (addr16),
      .addr26    (addr26),
      .ext_op    (ext_op),
      .imm32     (imm32),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b1; in_instr = 32'h1; in_pc = 32'h0;
      flush = 1'b0; out_ready = 1'b0; ext_op = 2'b01;

      // reset held for two edges with in_valid high
      tick(); tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      in_valid = 1'b0; reset_n = 1'b1; #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // field split and extension
      in_valid = 1'b1; in_instr = 32'h8C28_FFFC; in_pc = 32'h0000_3000; #1;
      chk("no_bypass", 32'(out_valid), 32'd0);
      tick(); in_valid = 1'b0; #1;
      chk("f_count", 32'(count), 32'd1);
      chk("f_op", 32'(op), 32'h23);
      chk("f_rs", 32'(rs), 32'd1);
      chk("f_rt", 32'(rt), 32'd8);
      chk("f_rd", 32'(rd), 32'h1F);
      chk("f_shamt", 32'(shamt), 32'h1F);
      chk("f_func", 32'(func), 32'h3C);
      chk("f_addr16", 32'(addr16), 32'hFFFC);
      chk("f_addr26", 32'(addr26), 32'h0028_FFFC);
      chk("f_pc", out_pc, 32'h3000);
      chk("imm_sign", imm32, 32'hFFFF_FFFC);
      ext_op = 2'b00; #1; chk("imm_zero", imm32, 32'h0000_FFFC);
      ext_op = 2'b10; #1; chk("imm_upper", imm32, 32'hFFFC_0000);
      ext_op = 2'b11; #1; chk("imm_rsvd", imm32, 32'h0);
      ext_op = 2'b01;
      out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
      chk("pop1_count", 32'(count), 32'd0);
      chk("empty_instr", out_instr, 32'h0);
      chk("empty_pc", out_pc, 32'h0);
      chk("empty_imm", imm32, 32'h0);

      // fill to full, reject a 5th, then wrap
      for (int k = 1; k <= 4; k++) begin
         in_valid = 1'b1; in_instr = 32'(k); in_pc = 32'h100 + 32'(4 * k);
         tick();
      end
      in_valid = 1'b0; #1;
      chk("full_count", 32'(count), 32'd4);
      chk("full_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1; in_instr = 32'd99; out_ready = 1'b1; #1;
      chk("full_pop_ready", 32'(in_ready), 32'd0);
      chk("head1", out_instr, 32'd1);
      tick(); in_valid = 1'b0; #1;
      chk("after_full_pop", 32'(count), 32'd3);
      chk("head2", out_instr, 32'd2);
      tick(); out_ready = 1'b0; #1;
      chk("half_count", 32'(count), 32'd2);
      for (int k = 5; k <= 6; k++) begin
         in_valid = 1'b1; in_instr = 32'(k); in_pc = 32'h100 + 32'(4 * k);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1; #1;
      chk("wrap_count", 32'(count), 32'd4);
      for (int k = 3; k <= 6; k++) begin
         chk($sformatf("wrap_instr%0d", k), out_instr, 32'(k));
         chk($sformatf("wrap_pc%0d", k), out_pc, 32'h100 + 32'(4 * k));
         tick();
      end
      out_ready = 1'b0; #1;
      chk("wrap_empty", 32'(count), 32'd0);

      // simultaneous push and pop at count 2
      in_valid = 1'b1; in_instr = 32'd7; tick();
      in_instr = 32'd8; tick();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_instr = 32'(9 + k); #1;
         chk($sformatf("pp_head%0d", k), out_instr, 32'(7 + k));
         tick();
         chk($sformatf("pp_count%0d", k), 32'(count), 32'd2);
      end
      in_valid = 1'b0; out_ready = 1'b0; #1;
      chk("pp_next", out_instr, 32'd10);

      // flush wins over push and pop
      in_valid = 1'b1; in_instr = 32'd12; tick();
      chk("pre_flush_count", 32'(count), 32'd3);
      flush = 1'b1; in_instr = 32'd13; out_ready = 1'b1; #1;
      chk("flush_ready", 32'(in_ready), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd1);
      tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid2", 32'(out_valid), 32'd0);
      chk("flush_instr", out_instr, 32'h0);
      in_valid = 1'b1; in_instr = 32'd14; in_pc = 32'h200; tick();
      in_valid = 1'b0; #1;
      chk("post_flush_count", 32'(count), 32'd1);
      chk("post_flush_head", out_instr, 32'd14);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // stall hold on the head at pc 0x3004
      in_valid = 1'b1; in_instr = 32'h8C28_FFFC; in_pc = 32'h0000_3004; tick();
      in_instr = 32'h0123_4567; in_pc = 32'h0000_3008; tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("hold_pc%0d", k), out_pc, 32'h3004);
         chk($sformatf("hold_instr%0d", k), out_instr, 32'h8C28_FFFC);
         chk($sformatf("hold_rt%0d", k), 32'(rt), 32'd8);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
      chk("hold_next", out_pc, 32'h3008);

      // reset mid-operation discards entries
      reset_n = 1'b0; tick();
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      reset_n = 1'b1; #1;
      chk("midrst_ready", 32'(in_ready), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised instruction buffer between fetch and decode.
- Queues up to DEPTH {pc, instruction} pairs using a valid/ready handshake.
- Presents the head entry pre-split into MIPS fields, plus a 32-bit immediate extended according to the selected mode.
- Supports a pipeline flush on branch/exception redirect, and lets fetch run ahead of a stalled decode stage.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- PC_W, 32, width of the stored program counter.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  queue accepts the entry this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc  input  PC_W  PC of in_instr.
- flush  input  1  discard all queued entries.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  PC_W  PC of the head entry.
- out_instr  output  32  head instruction word.
- op  output  6  head[31:26].
- rs  output  5  head[25:21].
- rt  output  5  head[20:16].
- rd  output  5  head[15:11].
- shamt  output  5  head[10:6].
- func  output  6  head[5:0].
- addr16  output  16  head[15:0].
- addr26  output  26  head[25:0].
- ext_op  input  2  immediate mode: 00 zero-ext, 01 sign-ext, 10 upper (addr16<<16), 11 reserved (yields 0).
- imm32  output  32  addr16 extended per ext_op.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries, each {pc, instr}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is tracked separately.
- Reset (reset_n low at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Storage contents are not cleared.
  - All outputs read as 0 except in_ready, which reads 1 once reset_n is high.
  - in_ready=0 while reset_n is low.
  - Reset mid-operation discards all entries exactly like flush.
- Handshake signals:
  - in_ready = reset_n && !flush && (count != DEPTH). It is combinational and does not depend on out_ready; a full queue never accepts in the same cycle it pops.
  - push = in_valid && in_ready.
  - out_valid = (count != 0). It does not depend on flush in the same cycle.
  - pop = out_valid && out_ready && !flush.
- Per-edge update, in priority order:
  1. !reset_n: reset.
  2. flush: rd_ptr<=wr_ptr, count<=0. Push and pop in that cycle are ignored.
  3. Otherwise:
     - push writes mem[wr_ptr] and increments wr_ptr.
     - pop increments rd_ptr.
     - count += push - pop. Simultaneous push and pop leaves count unchanged.
- Latency: an entry pushed into an empty queue appears on the outputs at the next cycle (1 cycle). There is no same-cycle bypass.
- Head outputs:
  - Combinational from mem[rd_ptr] when out_valid.
  - When out_valid=0: out_instr, out_pc, all fields and imm32 are forced to 0 (NOP), so decode sees sll $0,$0,0.
- Immediate extension:
  - sign-ext = {{16{addr16[15]}}, addr16}.
  - zero-ext = {16'b0, addr16}.
  - upper = {addr16, 16'b0}.
  - ext_op is sampled combinationally against the current head.
- Ordering: entries leave in strict push order; no reorder, no drop except on flush.
- Data rules: out_pc, out_instr and fields are stable while out_valid && !out_ready (stall hold).

Decomposition:
- Shared package (mips_pkg):
  - Field bit-position constants: OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SH_HI/LO, FN_HI/LO.
  - ext_op encodings: EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_UPPER=2'b10.
  - NOP_WORD=32'h0000_0000.
- Sub-module: instr_fields.
  - Purely combinational: 32-bit word + ext_op -> op/rs/rt/rd/shamt/func/addr16/addr26/imm32.
  - Instantiated once on the gated head word.

Test Plan:
1. Reset:
   - Stimulus: hold reset_n=0 for 2 cycles with in_valid=1.
   - Response: in_ready=0, out_valid=0, count=0, out_instr=0.
   - After release: in_ready=1.
2. Field split and extension:
   - Stimulus: push 32'h8C28_FFFC (lw $8,-4($1)) at pc 32'h0000_3000, ext_op=01.
   - Response next cycle: op=6'h23, rs=1, rt=8, addr16=16'hFFFC, imm32=32'hFFFF_FFFC, out_pc=32'h3000.
   - Response with ext_op=00: imm32=32'h0000_FFFC. With ext_op=10: imm32=32'hFFFC_0000.
3. Full and wrap-around (DEPTH=4):
   - Stimulus: push 4 entries with out_ready=0.
   - Response: count=4, in_ready=0; a 5th push is not accepted.
   - Then pop 2 and push 2: entries emerge in order 1..6 across the pointer wrap.
4. Simultaneous push and pop:
   - Stimulus: with count=2, in_valid=1 and out_ready=1 for 3 cycles.
   - Response: count stays 2; output sequence is preserved.
5. Flush priority:
   - Stimulus: count=3, assert flush with in_valid=1 and out_ready=1 in the same cycle.
   - Response: next cycle count=0, out_valid=0, out_instr=0; the offered entry is dropped.
   - The following cycle's push appears alone at the head.
6. Stall hold:
   - Stimulus: out_ready=0 for 5 cycles with the head at pc 32'h3004.
   - Response: out_pc, out_instr and fields remain constant each cycle.
